// File: rtl/seg7_monitor.sv
// Seven-segment receive-side checker: synchronises the segment bus, waits for each
// pattern to settle, decodes it and checks the digits form an incrementing, wrapping count.
module seg7_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int WRAP_DIGIT    = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] segments,
  input  logic       enable,
  input  logic       clear,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       code_error,
  output logic       seq_error,
  output logic [7:0] accept_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    STABLE = 2'd2
  } state_t;

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);
  localparam logic [3:0] WRAP_D   = 4'(WRAP_DIGIT);

  state_t     state;
  logic [6:0] s1;
  logic [6:0] s2;
  logic [7:0] cnt;
  logic [6:0] last_pat;
  logic       has_last;

  // Returns {valid, digit}; blank and unknown patterns both return valid=0.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F:   decode = 5'h10;
      7'h06:   decode = 5'h11;
      7'h5B:   decode = 5'h12;
      7'h4F:   decode = 5'h13;
      7'h66:   decode = 5'h14;
      7'h6D:   decode = 5'h15;
      7'h7D:   decode = 5'h16;
      7'h07:   decode = 5'h17;
      7'h7F:   decode = 5'h18;
      7'h6F:   decode = 5'h19;
      7'h77:   decode = 5'h1A;
      7'h7C:   decode = 5'h1B;
      7'h39:   decode = 5'h1C;
      7'h5E:   decode = 5'h1D;
      7'h79:   decode = 5'h1E;
      7'h71:   decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  logic [4:0] dec;
  logic       changed;
  logic [3:0] expected;
  logic       mismatch;
  logic       is_repeat;

  always_comb begin
    dec       = decode(s2);
    changed   = (s1 != s2);
    expected  = (digit == WRAP_D) ? 4'd0 : digit + 4'd1;
    mismatch  = (dec[3:0] > WRAP_D) || (dec[3:0] != expected);
    is_repeat = has_last && (s2 == last_pat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      s1           <= '0;
      s2           <= '0;
      cnt          <= '0;
      last_pat     <= '0;
      has_last     <= 1'b0;
      digit        <= '0;
      digit_valid  <= 1'b0;
      code_error   <= 1'b0;
      seq_error    <= 1'b0;
      accept_count <= '0;
    end else begin
      s1          <= segments;
      s2          <= s1;
      digit_valid <= 1'b0;
      if (clear) begin
        code_error   <= 1'b0;
        seq_error    <= 1'b0;
        accept_count <= '0;
        digit        <= '0;
        last_pat     <= '0;
        has_last     <= 1'b0;
        cnt          <= '0;
        state        <= enable ? SETTLE : IDLE;
      end else if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= SETTLE;
            cnt   <= '0;
          end
          SETTLE: begin
            if (changed) begin
              cnt <= '0;
            end else if (cnt == STABLE_N) begin
              state <= STABLE;
              // Single evaluation of the settled pattern
              if (s2 != 7'h00) begin
                if (!dec[4]) begin
                  code_error <= 1'b1;
                end else if (!is_repeat) begin
                  digit       <= dec[3:0];
                  digit_valid <= 1'b1;
                  last_pat    <= s2;
                  has_last    <= 1'b1;
                  if (accept_count != 8'hFF) accept_count <= accept_count + 8'd1;
                  if (has_last && mismatch) seq_error <= 1'b1;
                end
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          STABLE: begin
            if (changed) begin
              state <= SETTLE;
              cnt   <= '0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_monitor.sv
// Bench for seg7_monitor: directed scenarios plus randomized traffic, all checked
// every cycle against a behavioural model of settle / decode / sequence rules.
module tb_seg7_monitor;

  localparam int S = 4;
  localparam int W = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] segments = 7'h00;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] digit;
  logic       digit_valid;
  logic       code_error;
  logic       seq_error;
  logic [7:0] accept_count;

  seg7_monitor #(.STABLE_CYCLES(S), .WRAP_DIGIT(W)) dut (
    .clk(clk), .rst_n(rst_n), .segments(segments), .enable(enable), .clear(clear),
    .digit(digit), .digit_valid(digit_valid), .code_error(code_error),
    .seq_error(seq_error), .accept_count(accept_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [6:0] pat_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (pat_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: sampled pipeline, run length of an unchanged pattern, history
  logic [6:0] m_s1, m_s2, m_last;
  bit         m_has, m_active, m_done;
  int         m_run, m_digit, m_count;
  bit         m_dv, m_ce, m_se;

  task automatic model_eval(input logic [6:0] p);
    int d, e;
    d = lookup(p);
    if (p == 7'h00) return;
    if (d < 0) begin
      m_ce = 1;
      return;
    end
    if (m_has && p == m_last) return;
    if (m_has) begin
      e = (m_digit == W) ? 0 : m_digit + 1;
      if (d > W || d != e) m_se = 1;
    end
    m_digit = d;
    m_dv    = 1;
    m_count = (m_count < 255) ? m_count + 1 : 255;
    m_last  = p;
    m_has   = 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_last = 0; m_has = 0; m_active = 0; m_done = 0;
      m_run = 0; m_digit = 0; m_count = 0; m_dv = 0; m_ce = 0; m_se = 0;
    end else begin
      m_dv = 0;
      if (clear) begin
        m_ce = 0; m_se = 0; m_count = 0; m_digit = 0; m_last = 0; m_has = 0;
        m_active = enable; m_run = 0; m_done = 0;
      end else if (!enable) begin
        m_active = 0; m_run = 0; m_done = 0;
      end else if (!m_active) begin
        m_active = 1; m_run = 0; m_done = 0;
      end else if (m_s1 != m_s2) begin
        m_run = 0; m_done = 0;
      end else if (!m_done) begin
        if (m_run == S) begin
          m_done = 1;
          model_eval(m_s2);
        end else begin
          m_run++;
        end
      end
      m_s2 = m_s1;
      m_s1 = segments;
    end
  end

  bit compare_on = 0;
  always @(negedge clk) begin
    if (compare_on && rst_n) begin
      cmp("digit", digit, m_digit);
      cmp("digit_valid", digit_valid, m_dv);
      cmp("code_error", code_error, m_ce);
      cmp("seq_error", seq_error, m_se);
      cmp("accept_count", accept_count, m_count);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic hold(input logic [6:0] p, input int n, output int pulses, output int lastd);
    segments = p;
    pulses = 0;
    lastd = -1;
    repeat (n) begin
      @(negedge clk);
      if (digit_valid) begin
        pulses++;
        lastd = digit;
      end
      step();
    end
  endtask

  initial begin
    int pulses, lastd, n, total;
    int wrap_d [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    logic [6:0] p;
    int sel, len;

    #12;
    cmp("reset_digit", digit, 0);
    cmp("reset_valid", digit_valid, 0);
    cmp("reset_count", accept_count, 0);
    cmp("reset_flags", {code_error, seq_error}, 0);
    step();
    rst_n = 1'b1;
    compare_on = 1;
    enable = 1'b1;
    hold(7'h00, 10, pulses, lastd);
    cmp("blank_start_pulses", pulses, 0);

    // Latency: first sample at edge k, pulse after edge k+S+2
    segments = 7'h3F;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (digit_valid) begin
        n = i;
        break;
      end
    end
    cmp("latency_edges", n, S + 3);
    cmp("latency_digit", digit, 0);
    cmp("latency_count", accept_count, 1);
    step();
    hold(7'h3F, 50, pulses, lastd);
    cmp("held_no_repulse", pulses, 0);

    // Wrap sequence
    pulse_clear();
    total = 0;
    for (int i = 0; i < 9; i++) begin
      hold(pat_tab[wrap_d[i]], 10, pulses, lastd);
      total += pulses;
      cmp("wrap_digit", lastd, wrap_d[i]);
    end
    cmp("wrap_pulses", total, 9);
    cmp("wrap_seq_error", seq_error, 0);
    cmp("wrap_count", accept_count, 9);

    // Glitches and sequence error
    hold(7'h06, 10, pulses, lastd);
    cmp("glitch_pre_digit", lastd, 1);
    segments = 7'h7F;
    step();
    hold(7'h06, 12, pulses, lastd);
    cmp("glitch_pulses", pulses, 0);
    hold(7'h4F, 10, pulses, lastd);
    cmp("skip_seq_error", seq_error, 1);
    hold(7'h66, 10, pulses, lastd);
    cmp("seq_error_sticky", seq_error, 1);

    // Invalid / blank / clear
    hold(7'h55, 10, pulses, lastd);
    cmp("invalid_code_error", code_error, 1);
    cmp("invalid_pulses", pulses, 0);
    segments = 7'h00;
    pulse_clear();
    cmp("clear_flags", {code_error, seq_error}, 0);
    cmp("clear_count", accept_count, 0);
    hold(7'h00, 10, pulses, lastd);
    cmp("blank_pulses", pulses, 0);
    cmp("blank_code_error", code_error, 0);
    hold(7'h66, 10, pulses, lastd);
    cmp("after_clear_digit", lastd, 4);
    cmp("after_clear_seq", seq_error, 0);
    cmp("after_clear_count", accept_count, 1);

    // Saturation
    pulse_clear();
    for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 7'h06 : 7'h3F, 9, pulses, lastd);
    cmp("saturated_count", accept_count, 255);

    // Clear on the accept edge wins
    hold(7'h3F, 10, pulses, lastd);
    segments = 7'h06;
    repeat (6) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmp("clear_prio_valid", digit_valid, 0);
    cmp("clear_prio_count", accept_count, 0);
    clear = 1'b0;
    hold(7'h06, 10, pulses, lastd);

    // Asynchronous reset mid-settle
    segments = 7'h5B;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rst_digit", digit, 0);
    cmp("async_rst_count", accept_count, 0);
    cmp("async_rst_flags", {digit_valid, code_error, seq_error}, 0);
    step();
    rst_n = 1'b1;
    hold(7'h5B, 4, pulses, lastd);
    cmp("post_reset_no_early_pulse", pulses, 0);
    hold(7'h5B, 10, pulses, lastd);

    // Randomized traffic checked by the model every cycle
    for (int t = 0; t < 400; t++) begin
      sel = $urandom_range(0, 19);
      if (sel < 16) p = pat_tab[sel];
      else if (sel == 16) p = 7'h00;
      else p = 7'($urandom);
      len = (sel == 19) ? 1 : $urandom_range(1, 12);
      segments = p;
      enable = ($urandom_range(0, 9) != 0);
      repeat (len) begin
        clear = ($urandom_range(0, 39) == 0);
        step();
      end
      clear = 1'b0;
    end
    step();
    compare_on = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
